// File: rtl/qspi_sram_responder_if.sv
// QSPI pin bundle between a bus-side initiator and the serial SRAM device.
// The initiator (master) drives select, clock and outbound data; the
// device (slave) returns read data together with its output enable.
interface qspi_sram_responder_if;
  logic       QSPI_CS_N;
  logic       QSPI_SCK;
  logic [3:0] QSPI_SIO_I;
  logic [3:0] QSPI_SIO_O;
  logic [3:0] QSPI_SIO_E;

  modport master (
    output QSPI_CS_N,
    output QSPI_SCK,
    output QSPI_SIO_I,
    input  QSPI_SIO_O,
    input  QSPI_SIO_E
  );

  modport slave (
    input  QSPI_CS_N,
    input  QSPI_SCK,
    input  QSPI_SIO_I,
    output QSPI_SIO_O,
    output QSPI_SIO_E
  );
endinterface

// File: rtl/qspi_sram_responder.sv
// Device-side QSPI serial SRAM (SQI sequential mode, 0x02 WRITE / 0x03 READ).
// The pins are oversampled with CLK; data is taken on synchronized SCK rises
// and read data is driven on synchronized SCK falls. Memory is not reset.
module qspi_sram_responder #(
  parameter int ADDR_W = 9,
  parameter int SYNC   = 2
) (
  input  logic              CLK,
  input  logic              RES_N,
  qspi_sram_responder_if.slave bus,
  output logic              CMD_ERR,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic [7:0]        DBG_RDATA
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_RDATA  = 3'd4,
    S_WDATA  = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  // Synchronizer chains; all three share the same depth so SIO stays aligned to SCK.
  logic [SYNC-1:0]      r_cs_sync;
  logic [SYNC-1:0]      r_sck_sync;
  logic [SYNC-1:0][3:0] r_sio_sync;
  logic                 r_sck_prev;

  state_t               r_state;
  logic [1:0]           r_cnt;
  logic [3:0]           r_cmd_hi;
  logic                 r_is_read;
  logic [ADDR_W-1:0]    r_addr;
  logic [3:0]           r_hi;
  logic                 r_phase;
  logic [3:0]           r_sio_o;
  logic [3:0]           r_sio_e;
  logic                 r_cmd_err;
  logic                 r_armed;
  logic [7:0]           r_mem [2**ADDR_W];

  logic                 w_cs_n;
  logic                 w_sck;
  logic [3:0]           w_sio;
  logic                 w_rise;
  logic                 w_fall;
  logic [7:0]           w_cmd;
  logic                 w_we;
  logic [7:0]           w_rd_byte;

  assign w_cs_n    = r_cs_sync[SYNC-1];
  assign w_sck     = r_sck_sync[SYNC-1];
  assign w_sio     = r_sio_sync[SYNC-1];
  assign w_rise    = w_sck & ~r_sck_prev;
  assign w_fall    = ~w_sck & r_sck_prev;
  assign w_cmd     = {r_cmd_hi, w_sio};
  assign w_rd_byte = r_mem[r_addr];
  assign w_we      = (r_state == S_WDATA) && !w_cs_n && w_rise && r_phase;

  assign bus.QSPI_SIO_O = r_sio_o;
  assign bus.QSPI_SIO_E = r_sio_e;
  assign CMD_ERR        = r_cmd_err;
  assign DBG_RDATA      = r_mem[DBG_ADDR];

  // Pin synchronizers plus previous-SCK flop for edge detection.
  // CS_N resets to "selected" so a frame cut by reset is not re-entered mid-way.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_cs_sync  <= '0;
      r_sck_sync <= '0;
      r_sio_sync <= '0;
      r_sck_prev <= 1'b0;
    end else begin
      r_cs_sync[0]  <= bus.QSPI_CS_N;
      r_sck_sync[0] <= bus.QSPI_SCK;
      r_sio_sync[0] <= bus.QSPI_SIO_I;
      for (int i = 1; i < SYNC; i++) begin
        r_cs_sync[i]  <= r_cs_sync[i-1];
        r_sck_sync[i] <= r_sck_sync[i-1];
        r_sio_sync[i] <= r_sio_sync[i-1];
      end
      r_sck_prev <= w_sck;
    end
  end

  // Frame decoder FSM with registered pin outputs; CS_N high overrides any SCK edge.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_cmd_hi  <= 4'd0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_hi      <= 4'd0;
      r_phase   <= 1'b0;
      r_sio_o   <= 4'd0;
      r_sio_e   <= 4'd0;
      r_cmd_err <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (w_cs_n) begin
        r_state <= S_IDLE;
        r_cnt   <= 2'd0;
        r_phase <= 1'b0;
        r_sio_o <= 4'd0;
        r_sio_e <= 4'd0;
        r_armed <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_armed) begin
              r_state <= S_CMD;
              r_cnt   <= 2'd0;
            end
          end
          S_CMD: begin
            if (w_rise) begin
              if (r_cnt == 2'd0) begin
                r_cmd_hi <= w_sio;
                r_cnt    <= 2'd1;
              end else if ((w_cmd == 8'h02) || (w_cmd == 8'h03)) begin
                r_is_read <= (w_cmd == 8'h03);
                r_state   <= S_ADDR;
                r_cnt     <= 2'd0;
              end else begin
                r_cmd_err <= 1'b1;
                r_state   <= S_IGNORE;
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              // Only the low ADDR_W bits of the 16-bit address survive the shift.
              r_addr <= ADDR_W'({r_addr, w_sio});
              r_cnt  <= r_cnt + 2'd1;
              if (r_cnt == 2'd3) begin
                r_state <= r_is_read ? S_DUMMY : S_WDATA;
                r_cnt   <= 2'd0;
                r_phase <= 1'b0;
              end
            end
          end
          S_DUMMY: begin
            if (w_rise) begin
              r_cnt <= r_cnt + 2'd1;
            end else if (w_fall && (r_cnt == 2'd2)) begin
              r_sio_e <= 4'hF;
              r_sio_o <= w_rd_byte[7:4];
              r_phase <= 1'b1;
              r_state <= S_RDATA;
            end
          end
          S_RDATA: begin
            if (w_fall) begin
              if (r_phase) begin
                r_sio_o <= w_rd_byte[3:0];
                r_addr  <= r_addr + ADDR_W'(1);
              end else begin
                r_sio_o <= w_rd_byte[7:4];
              end
              r_phase <= ~r_phase;
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              if (r_phase) begin
                r_addr <= r_addr + ADDR_W'(1);
              end else begin
                r_hi <= w_sio;
              end
              r_phase <= ~r_phase;
            end
          end
          S_IGNORE: begin
            r_sio_e <= 4'd0;
          end
          default: begin
            r_state <= S_IGNORE;
          end
        endcase
      end
    end
  end

  // Byte array write port; the array itself carries no reset.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[r_addr] <= {r_hi, w_sio};
    end
  end

endmodule
